regfile_wb_buffer: RTL and testbench

Writer-side companion to the per-core register file. It buffers writeback requests from the pipeline in a small FIFO and drains them one per cycle onto the register file write port (WEN/wsel/wdat). It also exposes a newest-pending-write forwarding lookup, so read paths see buffered values before they are committed. The block sits between the pipeline's writeback stage and the register file interface.

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/regfile_wb_buffer_if.sv | 38 +++
 rtl/wb_fifo.sv | 62 ++++++
 rtl/regfile_wb_buffer.sv | 87 ++++++++
 tb/tb_regfile_wb_buffer.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types plus the writeback buffer entry format.
package cpu_types_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned REG_W  = 5;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [REG_W-1:0]  regbits_t;

   // One pending register file write.
   typedef struct packed {
      regbits_t sel;
      word_t    dat;
   } wb_entry_t;

   localparam int unsigned WB_DEPTH_DEFAULT = 4;
   localparam int unsigned WB_ENTRY_W       = $bits(wb_entry_t);

endpackage

// File: rtl/regfile_wb_buffer_if.sv
// Writeback request, register file write port and forwarding lookup bundle.
interface regfile_wb_buffer_if
   import cpu_types_pkg::*;
#(
   parameter int unsigned DEPTH = WB_DEPTH_DEFAULT
);

   logic                  wb_valid;
   logic                  wb_ready;
   regbits_t              wb_sel;
   word_t                 wb_dat;
   logic                  rf_hold;
   logic                  rf_wen;
   regbits_t              rf_wsel;
   word_t                 rf_wdat;
   regbits_t              fwd_sel1;
   regbits_t              fwd_sel2;
   logic                  fwd_hit1;
   logic                  fwd_hit2;
   word_t                 fwd_dat1;
   word_t                 fwd_dat2;
   logic [$clog2(DEPTH):0] count;

   // Pipeline / register file side.
   modport master (
      output wb_valid, wb_sel, wb_dat, rf_hold, fwd_sel1, fwd_sel2,
      input  wb_ready, rf_wen, rf_wsel, rf_wdat,
      input  fwd_hit1, fwd_hit2, fwd_dat1, fwd_dat2, count
   );

   // Buffer side.
   modport slave (
      input  wb_valid, wb_sel, wb_dat, rf_hold, fwd_sel1, fwd_sel2,
      output wb_ready, rf_wen, rf_wsel, rf_wdat,
      output fwd_hit1, fwd_hit2, fwd_dat1, fwd_dat2, count
   );

endinterface

// File: rtl/wb_fifo.sv
// Circular FIFO of pending writes; exposes all slots in age order (0 = oldest).
module wb_fifo
   import cpu_types_pkg::*;
#(
   parameter int unsigned DEPTH = WB_DEPTH_DEFAULT
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic                          pop,
   input  wb_entry_t                     din,
   output wb_entry_t                     head,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(DEPTH):0]        count,
   output logic [DEPTH*WB_ENTRY_W-1:0]   entries
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   wb_entry_t          mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   cnt;

   // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            cnt <= cnt + 1'b1;
         end else if (pop && !push) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   // Age-ordered flat view of the storage for the forwarding match.
   always_comb begin
      entries = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         entries[i*WB_ENTRY_W +: WB_ENTRY_W] = mem[rd_ptr + PTR_W'(i)];
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (cnt == CNT_W'(DEPTH));
   assign empty = (cnt == '0);
   assign count = cnt;

endmodule

// File: rtl/regfile_wb_buffer.sv
// Writeback buffer in front of the register file write port, with
// newest-pending-write forwarding (enabled by REGFILE_WB_FWD_EN).
module regfile_wb_buffer
   import cpu_types_pkg::*;
#(
   parameter int unsigned DEPTH = WB_DEPTH_DEFAULT
) (
   input  logic                 CLK,
   input  logic                 RST,
   regfile_wb_buffer_if.slave   bus
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic                        push;
   logic                        pop;
   logic                        full;
   logic                        empty;
   wb_entry_t                   head;
   logic [CNT_W-1:0]            cnt;
   logic [DEPTH*WB_ENTRY_W-1:0] entries;

   // Register 0 writes complete the handshake but are never stored.
   assign push = bus.wb_valid && !full && (bus.wb_sel != '0);
   assign pop  = !empty && !bus.rf_hold && !RST;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (CLK),
      .rst     (RST),
      .push    (push),
      .pop     (pop),
      .din     ('{sel: bus.wb_sel, dat: bus.wb_dat}),
      .head    (head),
      .full    (full),
      .empty   (empty),
      .count   (cnt),
      .entries (entries)
   );

   assign bus.wb_ready = !full;
   assign bus.count    = cnt;

   // Drive the head entry onto the write port in the cycle it is popped.
   always_comb begin
      bus.rf_wen  = 1'b0;
      bus.rf_wsel = '0;
      bus.rf_wdat = '0;
      if (pop) begin
         bus.rf_wen  = 1'b1;
         bus.rf_wsel = head.sel;
         bus.rf_wdat = head.dat;
      end
   end

`ifdef REGFILE_WB_FWD_EN
   // Scan oldest to youngest so the youngest occupied match overrides.
   always_comb begin
      wb_entry_t e;
      e            = '0;
      bus.fwd_hit1 = 1'b0;
      bus.fwd_hit2 = 1'b0;
      bus.fwd_dat1 = '0;
      bus.fwd_dat2 = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         e = entries[i*WB_ENTRY_W +: WB_ENTRY_W];
         if (CNT_W'(i) < cnt) begin
            if ((bus.fwd_sel1 != '0) && (e.sel == bus.fwd_sel1)) begin
               bus.fwd_hit1 = 1'b1;
               bus.fwd_dat1 = e.dat;
            end
            if ((bus.fwd_sel2 != '0) && (e.sel == bus.fwd_sel2)) begin
               bus.fwd_hit2 = 1'b1;
               bus.fwd_dat2 = e.dat;
            end
         end
      end
   end
`else
   logic unused_fwd;
   assign unused_fwd   = ^{entries, bus.fwd_sel1, bus.fwd_sel2};
   assign bus.fwd_hit1 = 1'b0;
   assign bus.fwd_hit2 = 1'b0;
   assign bus.fwd_dat1 = '0;
   assign bus.fwd_dat2 = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Self-checking bench for regfile_wb_buffer against a queue-based model.
module tb_regfile_wb_buffer;

   localparam int unsigned DEPTH = 4;
`ifdef REGFILE_WB_FWD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   typedef struct {
      logic [4:0]  sel;
      logic [31:0] dat;
   } m_entry_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   m_entry_t q[$];

   regfile_wb_buffer_if #(.DEPTH(DEPTH)) bus ();

   regfile_wb_buffer #(.DEPTH(DEPTH)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Youngest pending write to register s, if forwarding exists.
   function automatic void fwd_exp(input logic [4:0] s, output logic hit, output logic [31:0] dat);
      hit = 1'b0;
      dat = '0;
      if (FWD_EN && s != 5'd0) begin
         foreach (q[i]) begin
            if (q[i].sel == s) begin
               hit = 1'b1;
               dat = q[i].dat;
            end
         end
      end
   endfunction

   // One cycle: drive inputs, check outputs against the model, then advance the model.
   task automatic step(input logic v, input logic [4:0] s, input logic [31:0] d,
                       input logic h, input logic r, input logic [4:0] f1, input logic [4:0] f2);
      logic        e_rdy, e_wen, h1, h2;
      logic [4:0]  e_sel;
      logic [31:0] e_dat, d1, d2;
      m_entry_t    ne;
      @(negedge clk);
      bus.wb_valid = v;
      bus.wb_sel   = s;
      bus.wb_dat   = d;
      bus.rf_hold  = h;
      bus.fwd_sel1 = f1;
      bus.fwd_sel2 = f2;
      rst          = r;
      #1;
      e_rdy = (q.size() < DEPTH);
      e_wen = !r && (q.size() > 0) && !h;
      e_sel = e_wen ? q[0].sel : 5'd0;
      e_dat = e_wen ? q[0].dat : 32'd0;
      fwd_exp(f1, h1, d1);
      fwd_exp(f2, h2, d2);
      chk("wb_ready", 32'(bus.wb_ready), 32'(e_rdy));
      chk("count",    32'(bus.count),    32'(q.size()));
      chk("rf_wen",   32'(bus.rf_wen),   32'(e_wen));
      chk("rf_wsel",  32'(bus.rf_wsel),  32'(e_sel));
      chk("rf_wdat",  bus.rf_wdat,       e_dat);
      chk("fwd_hit1", 32'(bus.fwd_hit1), 32'(h1));
      chk("fwd_dat1", bus.fwd_dat1,      d1);
      chk("fwd_hit2", 32'(bus.fwd_hit2), 32'(h2));
      chk("fwd_dat2", bus.fwd_dat2,      d2);
      if (r) begin
         q.delete();
      end else begin
         if (e_wen) void'(q.pop_front());
         if (v && e_rdy && s != 5'd0) begin
            ne.sel = s;
            ne.dat = d;
            q.push_back(ne);
         end
      end
   endtask

   initial begin
      bus.wb_valid = 1'b0;
      bus.wb_sel   = '0;
      bus.wb_dat   = '0;
      bus.rf_hold  = 1'b0;
      bus.fwd_sel1 = '0;
      bus.fwd_sel2 = '0;

      // Reset
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);

      // Single write latency
      step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 5, 0);
      chk("lat_wen",  32'(bus.rf_wen),  32'd1);
      chk("lat_wsel", 32'(bus.rf_wsel), 32'd5);
      chk("lat_wdat", bus.rf_wdat,      32'hDEADBEEF);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("lat_cnt0", 32'(bus.count),   32'd0);

      // Fill under hold, refuse fifth push, then drain in order
      for (int i = 1; i <= 4; i++) step(1, 5'(i), 32'(i * 17), 1, 0, 0, 0);
      step(1, 9, 32'h55, 1, 0, 0, 0);
      chk("full_ready", 32'(bus.wb_ready), 32'd0);
      chk("full_cnt",   32'(bus.count),    32'd4);
      for (int k = 1; k <= 4; k++) begin
         step(0, 0, 0, 0, 0, 0, 0);
         chk("drain_sel", 32'(bus.rf_wsel), 32'(k));
         chk("drain_dat", bus.rf_wdat,      32'(k * 17));
      end
      step(0, 0, 0, 0, 0, 0, 0);

      // Newest matching write forwards; select 0 never hits
      step(1, 7, 32'hA, 1, 0, 7, 0);
      step(1, 7, 32'hB, 1, 0, 7, 0);
      step(0, 0, 0, 1, 0, 7, 0);
      chk("fwd_new_hit", 32'(bus.fwd_hit1), 32'(FWD_EN));
      chk("fwd_new_dat", bus.fwd_dat1,      FWD_EN ? 32'hB : 32'h0);
      chk("fwd_sel0",    32'(bus.fwd_hit2), 32'd0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 7, 7);

      // Register 0 write is accepted but discarded
      step(1, 0, 32'h1234, 0, 0, 0, 0);
      chk("r0_ready", 32'(bus.wb_ready), 32'd1);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("r0_cnt", 32'(bus.count),  32'd0);
      chk("r0_wen", 32'(bus.rf_wen), 32'd0);

      // Reset with a full buffer discards everything, no write during reset
      for (int i = 0; i < 4; i++) step(1, 5'(i + 10), $urandom, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 10, 11);
      chk("rst_wen", 32'(bus.rf_wen), 32'd0);
      step(0, 0, 0, 0, 0, 10, 11);
      chk("rst_cnt",   32'(bus.count),    32'd0);
      chk("rst_ready", 32'(bus.wb_ready), 32'd1);
      chk("rst_wen2",  32'(bus.rf_wen),   32'd0);

      // Steady push+pop at count 2 across pointer wrap
      step(1, 1, $urandom, 1, 0, 0, 0);
      step(1, 2, $urandom, 1, 0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         step(1, 5'($urandom_range(1, 31)), $urandom, 0, 0, 5'($urandom_range(0, 31)), 0);
         chk("pp_cnt", 32'(bus.count), 32'd2);
      end
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 60) == 0),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
